pattern_lut_cclut_pipe: RTL and testbench
=========================================

# pattern_lut_cclut_pipe

Parametrised, pipelined successor to the two-channel CCLUT pattern lookup. It serves NCH pattern channels per bunch crossing. It holds one runtime-writable 2^MXPATC x 18 table per enabled pattern ID and self-clears all tables after reset. Each channel's comparator code is mapped to offset, bend and quality with fixed 2-clock latency and a valid flag. It sits between the pattern finder's best-pattern sorter and the CLCT builder; the write/readback port hangs off the VME register decoder.

## Interface
- NCH, 2, number of pattern channels
- MXHITB, 3, hit-count field width in pattern word
- MXPIDB, 4, pattern-ID field width in pattern word
- MXPATC, 12, comparator-code (table address) width
- MXOFFSB, 4, offset field width
- MXBNDB, 5, bend field width
- MXQLTB, 9, quality field width
- PAT_EN, 16'h07C0, per-PID table enable mask (default PIDs 6..A)
- clock  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- vld_in  in  1  inputs valid this cycle
- pat_in  in  NCH*(MXHITB+MXPIDB)  per channel {hits, pid}, channel 0 in LSBs
- carry_in  in  NCH*MXPATC  per-channel comparator code
- clr_req  in  1  pulse: restart table clear sequence
- wr_en  in  1  table write strobe
- wr_pid  in  MXPIDB  table select for write/readback
- wr_adr  in  MXPATC  table address for write/readback
- wr_data  in  18  {offs[17:14], bend[13:9], quality[8:0]}
- wr_ack  out  1  write accepted, one cycle after wr_en
- rdbk_data  out  18  table contents at {wr_pid, wr_adr}, registered
- lut_ready  out  1  tables initialised, lookups valid
- vld_out  out  1  outputs valid
- offs_out  out  NCH*MXOFFSB  per-channel offset
- bend_out  out  NCH*MXBNDB  per-channel bend
- qlt_out  out  NCH*MXQLTB  per-channel quality
- miss_out  out  NCH  channel PID disabled/out of range, or lut_ready low

## Operation
- FSM states: CLEAR, READY.
- Reset asserted: state CLEAR, clear counter 0, all outputs 0. Reset does not touch table storage.
- CLEAR: each cycle writes 18'h0 to address = counter in every enabled table in parallel; counter +1.
- CLEAR exit: after address 2^MXPATC-1 is written -> READY, lut_ready=1 next cycle.
- READY: clr_req -> CLEAR, counter 0, lut_ready=0 next cycle. clr_req during CLEAR restarts the counter at 0.
- Write: wr_en in READY with PAT_EN[wr_pid]=1 writes the table -> wr_ack=1 next cycle.
- Write rejected (wr_ack stays 0, no write): wr_en during CLEAR, or with a disabled/out-of-range PID.
- Readback: rdbk_data registered every cycle from {wr_pid, wr_adr}; 0 for disabled PID.
- Readback same-cycle write: returns old data (read-first).
- Lookup per channel c: pid = pat_in[c][MXPIDB-1:0], address = carry_in[c].
- Lookup data: table[pid][address] when PAT_EN[pid]=1 and lut_ready=1, else 0 with miss_out[c]=1.
- Lookup vs write, same address same cycle: returns old data.
- Channels independent; any number of channels may hit the same table/address in the same cycle.
- vld_in=0: pipeline still advances; vld_out=0 and data outputs forced 0.

## Timing
- Stage 1 (edge N): register vld_in, pid, carry, and lut_ready snapshot; table read issued.
- Stage 2 (edge N+1): read data demuxed by pid, field-split, registered. Outputs valid after edge N+1, i.e. 2-clock latency, fully pipelined, one lookup set per clock.
- Clear duration: 2^MXPATC cycles (4096 default); lut_ready rises on the cycle after the last clear write.
- wr_ack and rdbk_data: 1-cycle latency.
- Reset asserted mid-pipeline: vld_out, data and miss_out go 0 immediately (async). In-flight lookups are discarded.
- Reset release: CLEAR starts on the first rising edge with reset_n=1.
- lut_ready snapshot at stage 1 governs miss; a clr_req arriving while a lookup is in flight does not alter that lookup.

## Test plan
- Reset release, hold vld_in=0 -> lut_ready=0 for 4096 cycles, then 1. Readback of PID 6 adr 12'h0FF = 0.
- Write PID 9 adr 12'h3A5 data 18'h2_5C1F; lookup ch0 pid 9 carry 3A5 at cycle N -> at N+2: offs 4'h9, bend 5'h0E, qlt 9'h01F, miss 0, vld_out 1.
- NCH=4, all channels pid A, same carry 12'h001 (written 18'h3_FFFF) -> all four channels return identical data in the same cycle.
- Lookup pid 5 (disabled) and pid B -> data 0, miss=1. wr_en to pid 5 -> wr_ack stays 0, readback 0.
- Same-cycle write of 18'h00001 and lookup at PID 7 adr 12'h010 (old 18'h00002) -> lookup and readback return 18'h00002; the next lookup returns 18'h00001.
- clr_req in READY, and separately reset_n low for 1 cycle mid-stream -> vld_out 0 at once, lut_ready 0, a full 4096-cycle clear runs, previously written entries read 0, and wr_en is rejected during the clear.

Source files
------------

// File: rtl/pattern_lut_cclut_pipe_if.sv
// Lookup, table write/readback and result bundle between the pattern sorter/VME decoder and the CCLUT.
// The master drives lookups and table access. The slave (the LUT pipe) returns results.
interface pattern_lut_cclut_pipe_if #(
  parameter int NCH     = 2,
  parameter int MXHITB  = 3,
  parameter int MXPIDB  = 4,
  parameter int MXPATC  = 12,
  parameter int MXOFFSB = 4,
  parameter int MXBNDB  = 5,
  parameter int MXQLTB  = 9
);
  logic                           vld_in;
  logic [NCH*(MXHITB+MXPIDB)-1:0] pat_in;
  logic [NCH*MXPATC-1:0]          carry_in;
  logic                           clr_req;
  logic                           wr_en;
  logic [MXPIDB-1:0]              wr_pid;
  logic [MXPATC-1:0]              wr_adr;
  logic [17:0]                    wr_data;
  logic                           wr_ack;
  logic [17:0]                    rdbk_data;
  logic                           lut_ready;
  logic                           vld_out;
  logic [NCH*MXOFFSB-1:0]         offs_out;
  logic [NCH*MXBNDB-1:0]          bend_out;
  logic [NCH*MXQLTB-1:0]          qlt_out;
  logic [NCH-1:0]                 miss_out;

  modport master (
    output vld_in, pat_in, carry_in, clr_req, wr_en, wr_pid, wr_adr, wr_data,
    input  wr_ack, rdbk_data, lut_ready, vld_out, offs_out, bend_out, qlt_out, miss_out
  );

  modport slave (
    input  vld_in, pat_in, carry_in, clr_req, wr_en, wr_pid, wr_adr, wr_data,
    output wr_ack, rdbk_data, lut_ready, vld_out, offs_out, bend_out, qlt_out, miss_out
  );
endinterface

// File: rtl/pattern_lut_cclut_pipe.sv
// Per-channel CCLUT lookup {pid, comparator code} -> {offset, bend, quality}, one writable table per enabled PID.
// Latency: 2 clocks per lookup set, 1 clock for wr_ack/readback. No backpressure: one lookup set is accepted every clock.
module pattern_lut_cclut_pipe #(
  parameter int NCH     = 2,
  parameter int MXHITB  = 3,
  parameter int MXPIDB  = 4,
  parameter int MXPATC  = 12,
  parameter int MXOFFSB = 4,
  parameter int MXBNDB  = 5,
  parameter int MXQLTB  = 9,
  parameter logic [(1<<MXPIDB)-1:0] PAT_EN = 16'h07C0
) (
  input logic                    clock,
  input logic                    reset_n,
  pattern_lut_cclut_pipe_if.slave bus
);
  localparam int NPID  = 1 << MXPIDB;
  localparam int DEPTH = 1 << MXPATC;
  localparam int PATW  = MXHITB + MXPIDB;
  localparam int LUTW  = 18;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q;
  logic [MXPATC-1:0] clr_cnt_q;
  logic              lut_ready_q;
  logic              wr_ack_q;
  logic [MXPIDB-1:0] rb_pid_q;

  logic              clearing;
  logic              wr_ok;
  logic [MXPATC-1:0] tab_adr;
  logic [LUTW-1:0]   tab_dat;

  // Clearing owns the table write port, so host writes are refused until the sweep finishes.
  assign clearing = (state_q == CLEAR);
  assign wr_ok    = bus.wr_en && !clearing && PAT_EN[bus.wr_pid];
  assign tab_adr  = clearing ? clr_cnt_q : bus.wr_adr;
  assign tab_dat  = clearing ? '0 : bus.wr_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      lut_ready_q <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      wr_ack_q <= wr_ok;
      case (state_q)
        CLEAR: begin
          if (bus.clr_req) begin
            clr_cnt_q <= '0;
          end else if (&clr_cnt_q) begin
            state_q     <= READY;
            clr_cnt_q   <= '0;
            lut_ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + MXPATC'(1);
          end
        end
        READY: begin
          if (bus.clr_req) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            lut_ready_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  logic [MXPIDB-1:0]     pid_in   [NCH];
  logic [MXPATC-1:0]     carry_in [NCH];
  logic [NCH*MXHITB-1:0] unused_hits;

  for (genvar c = 0; c < NCH; c++) begin : g_unpack
    assign pid_in[c]   = bus.pat_in[c*PATW +: MXPIDB];
    assign carry_in[c] = bus.carry_in[c*MXPATC +: MXPATC];
    assign unused_hits[c*MXHITB +: MXHITB] = bus.pat_in[c*PATW+MXPIDB +: MXHITB];
  end

  logic [LUTW-1:0] rd_dat [NPID][NCH];
  logic [LUTW-1:0] rb_dat [NPID];

  // Every table reads on the same edge it may be written, so lookups and readback see pre-write data.
  for (genvar p = 0; p < NPID; p++) begin : g_tab
    if (PAT_EN[p]) begin : g_en
      logic [LUTW-1:0] mem [DEPTH];
      logic [LUTW-1:0] rd_q [NCH];
      logic [LUTW-1:0] rb_q;
      logic            tab_we;

      assign tab_we = clearing || (wr_ok && (bus.wr_pid == MXPIDB'(p)));

      always_ff @(posedge clock) begin
        if (tab_we) mem[tab_adr] <= tab_dat;
        for (int c = 0; c < NCH; c++) rd_q[c] <= mem[carry_in[c]];
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rb_q <= '0;
        else          rb_q <= mem[bus.wr_adr];
      end

      for (genvar c = 0; c < NCH; c++) begin : g_rd
        assign rd_dat[p][c] = rd_q[c];
      end
      assign rb_dat[p] = rb_q;
    end else begin : g_dis
      for (genvar c = 0; c < NCH; c++) begin : g_rd
        assign rd_dat[p][c] = '0;
      end
      assign rb_dat[p] = '0;
    end
  end

  logic              vld_s1_q;
  logic              rdy_s1_q;
  logic [MXPIDB-1:0] pid_s1_q [NCH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_s1_q <= 1'b0;
      rdy_s1_q <= 1'b0;
      rb_pid_q <= '0;
      for (int c = 0; c < NCH; c++) pid_s1_q[c] <= '0;
    end else begin
      vld_s1_q <= bus.vld_in;
      rdy_s1_q <= lut_ready_q;
      rb_pid_q <= bus.wr_pid;
      for (int c = 0; c < NCH; c++) pid_s1_q[c] <= pid_in[c];
    end
  end

  logic [NCH*MXOFFSB-1:0] offs_d, offs_q;
  logic [NCH*MXBNDB-1:0]  bend_d, bend_q;
  logic [NCH*MXQLTB-1:0]  qlt_d,  qlt_q;
  logic [NCH-1:0]         miss_d, miss_q;
  logic                   vld_out_q;

  // The ready snapshot taken with the lookup decides hit/miss, so a later clr_req cannot disturb it.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic            hit;
    logic [LUTW-1:0] sel;
    assign hit = rdy_s1_q && PAT_EN[pid_s1_q[c]];
    assign sel = (vld_s1_q && hit) ? rd_dat[pid_s1_q[c]][c] : '0;
    assign offs_d[c*MXOFFSB +: MXOFFSB] = sel[MXBNDB+MXQLTB +: MXOFFSB];
    assign bend_d[c*MXBNDB +: MXBNDB]   = sel[MXQLTB +: MXBNDB];
    assign qlt_d[c*MXQLTB +: MXQLTB]    = sel[0 +: MXQLTB];
    assign miss_d[c] = vld_s1_q && !hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_out_q <= 1'b0;
      offs_q    <= '0;
      bend_q    <= '0;
      qlt_q     <= '0;
      miss_q    <= '0;
    end else begin
      vld_out_q <= vld_s1_q;
      offs_q    <= offs_d;
      bend_q    <= bend_d;
      qlt_q     <= qlt_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.wr_ack    = wr_ack_q;
  assign bus.rdbk_data = rb_dat[rb_pid_q];
  assign bus.lut_ready = lut_ready_q;
  assign bus.vld_out   = vld_out_q;
  assign bus.offs_out  = offs_q;
  assign bus.bend_out  = bend_q;
  assign bus.qlt_out   = qlt_q;
  assign bus.miss_out  = miss_q;
endmodule

// File: tb/tb_pattern_lut_cclut_pipe.sv
// Directed bench for pattern_lut_cclut_pipe with four channels: clear sweep, write/readback, lookup, miss and reset behaviour.
module tb_pattern_lut_cclut_pipe;
  localparam int NCH = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   start   = 0;

  pattern_lut_cclut_pipe_if #(.NCH(NCH)) bus();

  pattern_lut_cclut_pipe #(.NCH(NCH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_ch(input int c, input logic [3:0] pid, input logic [11:0] carry);
    bus.pat_in[c*7 +: 7]     = {3'b101, pid};
    bus.carry_in[c*12 +: 12] = carry;
  endtask

  function automatic logic [17:0] lut(input int c);
    return {bus.offs_out[c*4 +: 4], bus.bend_out[c*5 +: 5], bus.qlt_out[c*9 +: 9]};
  endfunction

  task automatic wr(input logic [3:0] pid, input logic [11:0] adr, input logic [17:0] dat,
                    input logic exp_ack, input string tag);
    bus.wr_en = 1'b1; bus.wr_pid = pid; bus.wr_adr = adr; bus.wr_data = dat;
    tick;
    bus.wr_en = 1'b0;
    chk(tag, bus.wr_ack, exp_ack);
  endtask

  task automatic rdbk(input logic [3:0] pid, input logic [11:0] adr, input logic [17:0] exp, input string tag);
    bus.wr_pid = pid; bus.wr_adr = adr;
    tick;
    chk(tag, bus.rdbk_data, exp);
  endtask

  task automatic lookup(input logic [15:0] pids, input logic [47:0] carries);
    for (int c = 0; c < NCH; c++) set_ch(c, pids[c*4 +: 4], carries[c*12 +: 12]);
    bus.vld_in = 1'b1;
    tick;
    bus.vld_in = 1'b0;
    tick;
  endtask

  task automatic wait_ready(input int from, input string tag);
    while (!bus.lut_ready && (cyc - from) < 5000) tick;
    chk(tag, cyc - from, 4096);
  endtask

  initial begin
    bus.vld_in = 1'b0; bus.pat_in = '0; bus.carry_in = '0; bus.clr_req = 1'b0;
    bus.wr_en = 1'b0; bus.wr_pid = '0; bus.wr_adr = '0; bus.wr_data = '0;
    tick; tick;
    chk("rst_vld", bus.vld_out, 0);
    chk("rst_ready", bus.lut_ready, 0);
    chk("rst_ack", bus.wr_ack, 0);
    chk("rst_miss", bus.miss_out, 0);
    chk("rst_qlt", bus.qlt_out, 0);
    chk("rst_rdbk", bus.rdbk_data, 0);

    reset_n = 1'b1;
    start   = cyc;
    wait_ready(start, "clr_len_rst");
    rdbk(4'h6, 12'h0FF, 18'h0, "rb_pid6_cleared");

    // ch0 hit, ch1 disabled pid, ch2 pid B, ch3 cleared entry.
    wr(4'h9, 12'h3A5, 18'h2_5C1F, 1'b1, "wr9_ack");
    lookup({4'h6, 4'hB, 4'h5, 4'h9}, {12'h000, 12'h3A5, 12'h3A5, 12'h3A5});
    chk("lk_vld", bus.vld_out, 1);
    chk("lk_offs", bus.offs_out[3:0], 4'h9);
    chk("lk_bend", bus.bend_out[4:0], 5'h0E);
    chk("lk_qlt", bus.qlt_out[8:0], 9'h01F);
    chk("lk_miss", bus.miss_out, 4'b0110);
    chk("lk_pid5_dat", lut(1), 0);
    chk("lk_pidB_dat", lut(2), 0);
    chk("lk_pid6_dat", lut(3), 0);
    tick;
    chk("idle_vld", bus.vld_out, 0);
    chk("idle_qlt", bus.qlt_out, 0);

    wr(4'hA, 12'h001, 18'h3_FFFF, 1'b1, "wrA_ack");
    lookup({4{4'hA}}, {4{12'h001}});
    for (int c = 0; c < NCH; c++) chk($sformatf("same_adr_ch%0d", c), lut(c), 18'h3_FFFF);
    chk("same_adr_miss", bus.miss_out, 0);

    wr(4'h5, 12'h010, 18'h0_0003, 1'b0, "wr5_rej");
    wr(4'hB, 12'h010, 18'h0_0003, 1'b0, "wrB_rej");
    rdbk(4'h5, 12'h010, 18'h0, "rb_pid5");

    // Write and lookup collide on the same edge, then a back-to-back lookup of the same entry.
    wr(4'h7, 12'h010, 18'h0_0002, 1'b1, "wr7_ack");
    set_ch(0, 4'h7, 12'h010);
    bus.vld_in = 1'b1; bus.wr_en = 1'b1; bus.wr_pid = 4'h7; bus.wr_adr = 12'h010; bus.wr_data = 18'h0_0001;
    tick;
    bus.wr_en = 1'b0;
    chk("rf_ack", bus.wr_ack, 1);
    chk("rf_rdbk", bus.rdbk_data, 18'h0_0002);
    tick;
    bus.vld_in = 1'b0;
    chk("rf_lookup_old", lut(0), 18'h0_0002);
    tick;
    chk("rf_lookup_new", lut(0), 18'h0_0001);
    rdbk(4'h7, 12'h010, 18'h0_0001, "rb_pid7_new");

    // clr_req with a lookup issued on the same edge: that lookup still hits.
    set_ch(0, 4'h9, 12'h3A5);
    bus.vld_in = 1'b1; bus.clr_req = 1'b1;
    tick;
    start = cyc;
    bus.vld_in = 1'b0; bus.clr_req = 1'b0;
    chk("clr_ready_low", bus.lut_ready, 0);
    tick;
    chk("clr_inflight_dat", lut(0), 18'h2_5C1F);
    chk("clr_inflight_miss", bus.miss_out[0], 0);
    lookup({4{4'hA}} & 16'hFFF0 | 16'h0009, {{3{12'h001}}, 12'h3A5});
    chk("clr_lk_miss", bus.miss_out, 4'hF);
    chk("clr_lk_dat", lut(0), 0);
    wr(4'h9, 12'h3A5, 18'h0_0001, 1'b0, "wr_during_clr");
    wait_ready(start, "clr_len_req");
    rdbk(4'h9, 12'h3A5, 18'h0, "rb_pid9_cleared");
    lookup({4{4'hA}}, {4{12'h001}});
    chk("post_clr_miss", bus.miss_out, 0);
    chk("post_clr_dat", lut(3), 0);

    // Asynchronous reset while a lookup result is on the outputs.
    wr(4'h8, 12'h020, 18'h0_1234, 1'b1, "wr8_ack");
    for (int c = 0; c < NCH; c++) set_ch(c, 4'h8, 12'h020);
    bus.vld_in = 1'b1;
    tick; tick;
    chk("pre_rst_vld", bus.vld_out, 1);
    chk("pre_rst_dat", lut(2), 18'h0_1234);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_vld", bus.vld_out, 0);
    chk("arst_dat", lut(2), 0);
    chk("arst_ready", bus.lut_ready, 0);
    bus.vld_in = 1'b0;
    tick;
    reset_n = 1'b1;
    start   = cyc;
    wr(4'h8, 12'h020, 18'h0_0005, 1'b0, "wr_during_rst_clr");
    wait_ready(start, "clr_len_arst");
    rdbk(4'h8, 12'h020, 18'h0, "rb_pid8_cleared");
    lookup({4{4'h8}}, {4{12'h020}});
    chk("post_arst_dat", lut(1), 0);
    chk("post_arst_miss", bus.miss_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
